regfile_port_arbiter: RTL

- Shares the 16x16 register file's single write port between two writeback requesters: port 0 is ALU writeback, port 1 is load writeback.
- Sequences the register file's paired read port (AA/BA) for the issue stage.
- Keeps a per-register pending-write scoreboard and stalls reads of registers with outstanding writes.
- Sits between issue/writeback logic and the register file; drives the register file's D/DA/AA/BA/RW inputs directly.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_port_arbiter_rr_arbiter2.sv | 38 +++
 rtl/regfile_port_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its port arbiter.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_LD  = 1'b1
  } port_e;

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant for the write port; priority goes to the port
// that did not win the last completed write.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  port_e rr_last_q, rr_last_d;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant_o   = 2'b00;
    rr_last_d = rr_last_q;
    if (!rst) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (rr_last_q == PORT_LD) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
    // A grant is only issued against a valid request, so a grant is a completed write.
    if (|grant_o) rr_last_d = grant_o[PORT_LD] ? PORT_LD : PORT_ALU;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= PORT_LD;
    else     rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the register file write port between ALU and load writeback,
// drives the paired read port, and stalls reads/reservations on pending writes.
module regfile_port_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_valid,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_aa,
  input  logic [ADDR_W-1:0] rd_ba,
  output logic              rd_ready,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rf_D,
  output logic [ADDR_W-1:0] rf_DA,
  output logic [ADDR_W-1:0] rf_AA,
  output logic [ADDR_W-1:0] rf_BA,
  output logic              rf_RW
);

  logic [1:0]          wr_grant;
  logic [1:0]          wr_fire;
  logic                collision;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic                rd_resp_valid_q, rd_resp_valid_d;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (wr_valid),
    .grant_o (wr_grant)
  );

  assign wr_ready = wr_grant;
  assign wr_fire  = wr_valid & wr_grant;
  assign rf_AA    = rd_aa;
  assign rf_BA    = rd_ba;

  always_comb begin
    rf_RW = |wr_fire;
    rf_DA = '0;
    rf_D  = '0;
    if (wr_fire[PORT_LD]) begin
      rf_DA = wr_addr1;
      rf_D  = wr_data1;
    end else if (wr_fire[PORT_ALU]) begin
      rf_DA = wr_addr0;
      rf_D  = wr_data0;
    end
  end

  // The register file reads pre-write data on a same-edge write, so a read
  // that hits the register being written this cycle must wait one cycle.
  always_comb begin
    collision       = rf_RW && ((rf_DA == rd_aa) || (rf_DA == rd_ba));
    rsv_ready       = !sb_q[rsv_addr];
    rd_ready        = !sb_q[rd_aa] && !sb_q[rd_ba] && !collision;
    rd_resp_valid_d = rd_valid && rd_ready;
    sb_d            = sb_q;
    if (rf_RW)                  sb_d[rf_DA]    = 1'b0;
    if (rsv_valid && rsv_ready) sb_d[rsv_addr] = 1'b1;
  end

  // NOTE: the scoreboard is a handful of flops whose cleared state is
  // architectural, so it is reset like any other control register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q            <= '0;
      rd_resp_valid_q <= 1'b0;
    end else begin
      sb_q            <= sb_d;
      rd_resp_valid_q <= rd_resp_valid_d;
    end
  end

  assign rd_resp_valid = rd_resp_valid_q;

endmodule
